trena_rx_comandos: RTL

Serial command receiver for the digital tape-measure (trena) system, on the opposite end of the 7E2 serial link from the trena transmitter. It deserializes 7-bit, even-parity, 2-stop-bit characters arriving on `RxD` and checks parity and framing. It decodes valid ASCII commands into single-cycle `mensurar` and `parar` pulses that feed the trena control unit, so a host terminal can start and stop measurements.

---
 rtl/trena_rx_comandos_if.sv | 46 ++++
 rtl/trena_rx_comandos.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/trena_rx_comandos_if.sv
// -----------------------------------------------------------------------------
// trena_rx_comandos_if
// Groups the serial input line and the decoded receiver outputs of the trena
// command receiver.
//   RxD            serial line, idles high
//   dado_recebido  last received 7-bit character
//   pronto_rx      one-cycle pulse per completed character
//   erro_paridade  parity error on last character (held)
//   erro_frame     stop-bit error on last character (held)
//   mensurar       one-cycle pulse on a valid 'm'/'M'
//   parar          one-cycle pulse on a valid 'p'/'P'
//   db_estado      current receiver FSM state code
// Modports: master = host/line side (drives RxD), slave = receiver.
// -----------------------------------------------------------------------------
interface trena_rx_comandos_if;
    logic       RxD;
    logic [6:0] dado_recebido;
    logic       pronto_rx;
    logic       erro_paridade;
    logic       erro_frame;
    logic       mensurar;
    logic       parar;
    logic [2:0] db_estado;

    modport master (
        output RxD,
        input  dado_recebido,
        input  pronto_rx,
        input  erro_paridade,
        input  erro_frame,
        input  mensurar,
        input  parar,
        input  db_estado
    );

    modport slave (
        input  RxD,
        output dado_recebido,
        output pronto_rx,
        output erro_paridade,
        output erro_frame,
        output mensurar,
        output parar,
        output db_estado
    );
endinterface

// File: rtl/trena_rx_comandos.sv
// -----------------------------------------------------------------------------
// trena_rx_comandos
// Serial 7E2 command receiver: deserializes 7 data bits (LSB first), one even
// parity bit and two stop bits, flags parity/framing errors and decodes
// 'm'/'M' into a mensurar pulse and 'p'/'P' into a parar pulse.
//
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      trena_rx_comandos_if.slave (RxD in; decoded outputs out)
//
// Parameter:
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//
// Optional feature macro: TRENA_RX_SYNC_EN
//   defined     -> RxD passes a 2-flop synchronizer (reset to 1) first
//   not defined -> RxD is used directly
// -----------------------------------------------------------------------------
module trena_rx_comandos #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic               clock,
    input  logic               reset_n,
    trena_rx_comandos_if.slave bus
);

    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] HalfM1 = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);

    localparam logic [6:0] ChM = 7'h4D;
    localparam logic [6:0] Chm = 7'h6D;
    localparam logic [6:0] ChP = 7'h50;
    localparam logic [6:0] Chp = 7'h70;

    typedef enum logic [2:0] {
        StInicial = 3'd0,
        StStart   = 3'd1,
        StRecebe  = 3'd2,
        StStop    = 3'd3,
        StFinal   = 3'd4
    } estado_e;

    estado_e estado_q, estado_d;

    // -------------------------------------------------------------------------
    // Line conditioning
    // -------------------------------------------------------------------------
    logic linha;
    logic linha_ok;

`ifdef TRENA_RX_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_vld_q;

    // sync_vld_q marks when sync_q[1] carries a real line sample rather than
    // its reset value, so a line held low through reset is not seen as a fall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b11;
            sync_vld_q <= 2'b00;
        end else begin
            sync_q     <= {sync_q[0], bus.RxD};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    assign linha    = sync_q[1];
    assign linha_ok = sync_vld_q[1];
`else
    assign linha    = bus.RxD;
    assign linha_ok = 1'b1;
`endif

    // Previous line level; resets low so the line must be seen high before a
    // falling edge can be detected.
    logic linha_ant_q;
    logic queda;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            linha_ant_q <= 1'b0;
        end else begin
            linha_ant_q <= linha & linha_ok;
        end
    end

    assign queda = linha_ant_q & ~linha & linha_ok;

    // -------------------------------------------------------------------------
    // Bit timing
    // -------------------------------------------------------------------------
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic            amostra;
    logic            ultimo_dado;
    logic            ultimo_stop;

    // In start the sample point is mid-start; afterwards one full bit apart.
    always_comb begin
        amostra = 1'b0;
        unique case (estado_q)
            StStart:         amostra = (cnt_q == HalfM1);
            StRecebe, StStop: amostra = (cnt_q == BitM1);
            default:         amostra = 1'b0;
        endcase
    end

    assign ultimo_dado = (estado_q == StRecebe) && amostra && (bit_q == 3'd7);
    assign ultimo_stop = (estado_q == StStop) && amostra && (bit_q == 3'd1);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= StInicial;
        end else begin
            estado_q <= estado_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StInicial: if (queda) estado_d = StStart;
            StStart: begin
                // High at mid-start means a glitch, not a start bit.
                if (amostra) estado_d = linha ? StInicial : StRecebe;
            end
            StRecebe:  if (ultimo_dado) estado_d = StStop;
            StStop:    if (ultimo_stop) estado_d = StFinal;
            StFinal:   estado_d = StInicial;
            default:   estado_d = StInicial;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: counters, shift register, error accumulation, commit
    // -------------------------------------------------------------------------
    logic [6:0] desloc_q;
    logic       paridade_q;
    logic       stop_err_q;
    logic [6:0] dado_q;
    logic       erro_par_q;
    logic       erro_frame_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            bit_q        <= '0;
            desloc_q     <= '0;
            paridade_q   <= 1'b0;
            stop_err_q   <= 1'b0;
            dado_q       <= '0;
            erro_par_q   <= 1'b0;
            erro_frame_q <= 1'b0;
        end else begin
            // Bit-period counter restarts at every sample point.
            if (estado_q == StInicial || amostra) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Bit index: 0..7 in recebe (7 data + parity), 0..1 in stop.
            if ((estado_q == StRecebe || estado_q == StStop) && amostra) begin
                bit_q <= (ultimo_dado || ultimo_stop) ? 3'd0 : bit_q + 3'd1;
            end else if (estado_q != StRecebe && estado_q != StStop) begin
                bit_q <= 3'd0;
            end

            if (estado_q == StStart) begin
                paridade_q <= 1'b0;
                stop_err_q <= 1'b0;
            end

            if (estado_q == StRecebe && amostra) begin
                paridade_q <= paridade_q ^ linha;
                if (bit_q != 3'd7) begin
                    desloc_q <= {linha, desloc_q[6:1]};
                end
            end

            if (estado_q == StStop && amostra) begin
                stop_err_q <= stop_err_q | ~linha;
            end

            // A detected start clears the held error flags.
            if (estado_q == StInicial && queda) begin
                erro_par_q   <= 1'b0;
                erro_frame_q <= 1'b0;
            end

            // Commit on the second stop sample so everything is visible in final.
            if (ultimo_stop) begin
                dado_q       <= desloc_q;
                erro_par_q   <= paridade_q;
                erro_frame_q <= stop_err_q | ~linha;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    logic valido;

    always_comb begin
        valido            = (estado_q == StFinal) && !erro_par_q && !erro_frame_q;
        bus.dado_recebido = dado_q;
        bus.erro_paridade = erro_par_q;
        bus.erro_frame    = erro_frame_q;
        bus.pronto_rx     = (estado_q == StFinal);
        bus.mensurar      = valido && (dado_q == Chm || dado_q == ChM);
        bus.parar         = valido && (dado_q == Chp || dado_q == ChP);
        bus.db_estado     = estado_q;
    end

endmodule
